// File: rtl/qe_bus_pkg.sv
// Shared types for the QL expansion-bus to W5300 cycle sequencer:
// FSM state encoding, counter widths and the registered output bundle.
package qe_bus_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_HOLD
  } qe_state_e;

  typedef struct packed {
    logic csl;
    logic rdl;
    logic wrl;
    logic dbenl;
    logic dbdir;
    logic dtackl;
  } qe_bus_out_t;

  localparam qe_bus_out_t BUS_IDLE = '{
    csl:    1'b1,
    rdl:    1'b1,
    wrl:    1'b1,
    dbenl:  1'b1,
    dbdir:  1'b0,
    dtackl: 1'b1
  };

  // Output levels to present while sitting in state st for an access of direction rw_q.
  function automatic qe_bus_out_t bus_outputs(input qe_state_e st, input logic rw_q);
    qe_bus_out_t o;
    o = BUS_IDLE;
    if (st != ST_IDLE) o.dbdir = ~rw_q;
    case (st)
      ST_SETUP: begin
        o.csl   = 1'b0;
        o.dbenl = 1'b0;
      end
      ST_STROBE: begin
        o.csl   = 1'b0;
        o.dbenl = 1'b0;
        o.rdl   = ~rw_q;
        o.wrl   = rw_q;
      end
      // Write strobe released here: that rising edge is where the W5300 latches data.
      ST_ACK: begin
        o.csl    = 1'b0;
        o.dbenl  = 1'b0;
        o.rdl    = ~rw_q;
        o.dtackl = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/qe_sync2.sv
// Two-flop synchroniser for an asynchronous level input, with a selectable reset level.
module qe_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetl,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/qe_wiz_cycle_ctrl.sv
// 68008 bus-cycle sequencer for the W5300: programmable setup/strobe/hold, buffer control, DTACK.
// Optional ACK watchdog enabled by defining QE_WIZ_TIMEOUT_EN.
module qe_wiz_cycle_ctrl
  import qe_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 3,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic clk,
  input  logic resetl,
  input  logic wizsel,
  input  logic dsl,
  input  logic rdwl,
  output logic wizcsl,
  output logic wizrdl,
  output logic wizwrl,
  output logic dbenl,
  output logic dbdir,
  output logic dtackl,
  output logic timeout
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  if (SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("qe_wiz_cycle_ctrl: timing parameter out of range");
  end

  logic w_wizsel_s;
  logic w_dsl_s;
  logic w_start;

  qe_sync2 #(.RST_VAL(1'b0)) u_sync_wizsel (
    .clk    (clk),
    .resetl (resetl),
    .i_d    (wizsel),
    .o_q    (w_wizsel_s)
  );

  qe_sync2 #(.RST_VAL(1'b1)) u_sync_dsl (
    .clk    (clk),
    .resetl (resetl),
    .i_d    (dsl),
    .o_q    (w_dsl_s)
  );

  assign w_start = w_wizsel_s & ~w_dsl_s;

  qe_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rw_q;
  qe_bus_out_t      r_out;
`ifdef QE_WIZ_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] r_tcnt;
  logic             r_timeout;
`endif

  // Outputs are registered alongside the state, so they always reflect the state being entered.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rw_q  <= 1'b1;
      r_out   <= BUS_IDLE;
`ifdef QE_WIZ_TIMEOUT_EN
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_rw_q <= rdwl;
            if (SETUP_CYC == 0) begin
              r_state <= ST_STROBE;
              r_cnt   <= STROBE_LD;
              r_out   <= bus_outputs(ST_STROBE, rdwl);
            end else begin
              r_state <= ST_SETUP;
              r_cnt   <= SETUP_LD;
              r_out   <= bus_outputs(ST_SETUP, rdwl);
            end
          end
        end

        ST_SETUP: begin
          if (w_dsl_s) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LD;
            r_out   <= bus_outputs(ST_HOLD, r_rw_q);
          end else if (r_cnt == '0) begin
            r_state <= ST_STROBE;
            r_cnt   <= STROBE_LD;
            r_out   <= bus_outputs(ST_STROBE, r_rw_q);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_STROBE: begin
          if (w_dsl_s) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LD;
            r_out   <= bus_outputs(ST_HOLD, r_rw_q);
          end else if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_out   <= bus_outputs(ST_ACK, r_rw_q);
`ifdef QE_WIZ_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        // Only the CPU releasing DS (or the watchdog) ends the access.
        ST_ACK: begin
          if (w_dsl_s) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LD;
            r_out   <= bus_outputs(ST_HOLD, r_rw_q);
          end
`ifdef QE_WIZ_TIMEOUT_EN
          else if (r_tcnt == TMO_LAST) begin
            r_state   <= ST_HOLD;
            r_cnt     <= HOLD_LD;
            r_out     <= bus_outputs(ST_HOLD, r_rw_q);
            r_timeout <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TMO_W'(1);
          end
`endif
        end

        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_out   <= BUS_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_out   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign wizcsl = r_out.csl;
  assign wizrdl = r_out.rdl;
  assign wizwrl = r_out.wrl;
  assign dbenl  = r_out.dbenl;
  assign dbdir  = r_out.dbdir;
  assign dtackl = r_out.dtackl;
`ifdef QE_WIZ_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_qe_wiz_cycle_ctrl.sv
// Bench for qe_wiz_cycle_ctrl: two instances (SETUP_CYC=1 and SETUP_CYC=0) driven in parallel,
// checked edge by edge against an event-time model plus directed event tables.
module tb_qe_wiz_cycle_ctrl;

  localparam int STB = 3;
  localparam int HLD = 1;
  localparam int TMO = 10;
  localparam logic [6:0] RST_V = 7'b1111010;

  logic clk;
  logic resetl, wizsel, dsl, rdwl;
  logic a_csl, a_rdl, a_wrl, a_dbenl, a_dbdir, a_dtackl, a_tmo;
  logic b_csl, b_rdl, b_wrl, b_dbenl, b_dbdir, b_dtackl, b_tmo;

  int checks = 0;
  int failures = 0;
  bit tmo_flag = 1'b0;
  int s_cyc [2] = '{1, 0};

  typedef struct {
    int   cs_fall;
    int   cs_rise;
    int   stb_fall;
    int   stb_rise;
    int   dt_fall;
    int   dt_rise;
    logic dir;
  } ev_t;
  ev_t ev [2];

  typedef struct {
    bit sel;
    bit rw;
    int len;
    int drop;
    bit flip;
    int cs_fall;
    int stb_fall;
    int stb_rise;
    int dt_fall;
    int dt_rise;
    int cs_rise;
    bit dir;
  } vec_t;
  vec_t tbl [7];

  qe_wiz_cycle_ctrl #(.SETUP_CYC(1), .STROBE_CYC(STB), .HOLD_CYC(HLD), .TIMEOUT_CYC(TMO)) u_dut (
    .clk(clk), .resetl(resetl), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
    .wizcsl(a_csl), .wizrdl(a_rdl), .wizwrl(a_wrl), .dbenl(a_dbenl),
    .dbdir(a_dbdir), .dtackl(a_dtackl), .timeout(a_tmo)
  );

  qe_wiz_cycle_ctrl #(.SETUP_CYC(0), .STROBE_CYC(STB), .HOLD_CYC(HLD), .TIMEOUT_CYC(TMO)) u_dut_s0 (
    .clk(clk), .resetl(resetl), .wizsel(wizsel), .dsl(dsl), .rdwl(rdwl),
    .wizcsl(b_csl), .wizrdl(b_rdl), .wizwrl(b_wrl), .dbenl(b_dbenl),
    .dbdir(b_dbdir), .dtackl(b_dtackl), .timeout(b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] outv(input int d);
    if (d == 0) return {a_csl, a_rdl, a_wrl, a_dbenl, a_dbdir, a_dtackl, a_tmo};
    return {b_csl, b_rdl, b_wrl, b_dbenl, b_dbdir, b_dtackl, b_tmo};
  endfunction

  // Expected {csl,rdl,wrl,dbenl,dbdir,dtackl,timeout} after edge n, from event times:
  // CS at edge 3, strobe after setup, DTACK after strobe, exit 3 edges after DS rises.
  function automatic logic [6:0] model_out(input int sc, input int n, input bit sel,
                                           input bit rw, input int len, input bit tf);
    int c_e, s_e, a_e, x_e;
    logic [6:0] v;
    v = {6'b111101, tf};
    if (!sel) return v;
    c_e = 3;
    s_e = c_e + sc;
    a_e = s_e + STB;
    x_e = len + 3;
    if (n >= c_e && n < x_e) begin
      if (n < a_e) v = {1'b0, ~(rw && n >= s_e), ~(!rw && n >= s_e), 1'b0, ~rw, 1'b1, tf};
      else         v = {1'b0, ~rw, 1'b1, 1'b0, ~rw, 1'b0, tf};
    end else if (n >= x_e && n < x_e + HLD) begin
      v = {4'b1111, ~rw, 1'b1, tf};
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic chk_vec(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b (csl,rdl,wrl,dbenl,dbdir,dtackl,timeout)",
               name, act, exp_v);
    end
  endtask

  // One bus access: DS low for len edges, optional early wizsel drop and rdwl flip after latch.
  task automatic run_txn(input bit sel, input bit rw, input int len, input int drop, input bit flip);
    int nmax;
    logic [6:0] act;
    nmax = sel ? len + 3 + HLD + 2 : len + 4;
    for (int d = 0; d < 2; d++) ev[d] = '{0, 0, 0, 0, 0, 0, 1'b0};
    @(posedge clk); #1;
    wizsel = sel;
    dsl    = 1'b0;
    rdwl   = rw;
    for (int n = 1; n <= nmax; n++) begin
      @(posedge clk); #1;
      if (n == len) dsl = 1'b1;
      if (n == drop) wizsel = 1'b0;
      if (flip && n == 3) rdwl = ~rdwl;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act = outv(d);
        chk_vec($sformatf("dut%0d edge%0d", d, n), act, model_out(s_cyc[d], n, sel, rw, len, tmo_flag));
        if (!act[6]) ev[d].dir = act[2];
        if (!act[6] && ev[d].cs_fall == 0) ev[d].cs_fall = n;
        if (act[6] && ev[d].cs_fall != 0 && ev[d].cs_rise == 0) ev[d].cs_rise = n;
        if (!(act[5] & act[4]) && ev[d].stb_fall == 0) ev[d].stb_fall = n;
        if ((act[5] & act[4]) && ev[d].stb_fall != 0 && ev[d].stb_rise == 0) ev[d].stb_rise = n;
        if (!act[1] && ev[d].dt_fall == 0) ev[d].dt_fall = n;
        if (act[1] && ev[d].dt_fall != 0 && ev[d].dt_rise == 0) ev[d].dt_rise = n;
      end
    end
    wizsel = 1'b0;
    dsl    = 1'b1;
  endtask

  task automatic run_random(input int count);
    bit sel, rw, flip;
    int len, drop;
    for (int t = 0; t < count; t++) begin
      sel  = ($urandom_range(0, 5) != 0);
      rw   = 1'($urandom_range(0, 1));
      len  = int'($urandom_range(1, 12));
      drop = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, len)) : 0;
      flip = 1'($urandom_range(0, 1));
      run_txn(sel, rw, len, drop, flip);
    end
  endtask

  initial begin
    //           sel rw len drop flip  csF stbF stbR dtF dtR csR dir
    tbl[0] = '{1'b1, 1'b1, 10, 4, 1'b0,  3, 4, 13, 7, 13, 13, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 10, 0, 1'b1,  3, 4,  7, 7, 13, 13, 1'b1};
    tbl[2] = '{1'b1, 1'b0,  2, 0, 1'b0,  3, 4,  5, 0,  0,  5, 1'b1};
    tbl[3] = '{1'b0, 1'b1,  6, 0, 1'b0,  0, 0,  0, 0,  0,  0, 1'b0};
    tbl[4] = '{1'b1, 1'b1,  4, 0, 1'b0,  3, 4,  7, 0,  0,  7, 1'b0};
    tbl[5] = '{1'b1, 1'b0,  5, 0, 1'b0,  3, 4,  7, 7,  8,  8, 1'b1};
    tbl[6] = '{1'b1, 1'b1,  1, 0, 1'b0,  3, 0,  0, 0,  0,  4, 1'b0};

    resetl = 1'b0;
    wizsel = 1'b0;
    dsl    = 1'b1;
    rdwl   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("reset dut0", outv(0), RST_V);
    chk_vec("reset dut1", outv(1), RST_V);
    @(posedge clk); #1;
    resetl = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].sel, tbl[i].rw, tbl[i].len, tbl[i].drop, tbl[i].flip);
      chk($sformatf("row%0d cs_fall", i),  ev[0].cs_fall,  tbl[i].cs_fall);
      chk($sformatf("row%0d stb_fall", i), ev[0].stb_fall, tbl[i].stb_fall);
      chk($sformatf("row%0d stb_rise", i), ev[0].stb_rise, tbl[i].stb_rise);
      chk($sformatf("row%0d dt_fall", i),  ev[0].dt_fall,  tbl[i].dt_fall);
      chk($sformatf("row%0d dt_rise", i),  ev[0].dt_rise,  tbl[i].dt_rise);
      chk($sformatf("row%0d cs_rise", i),  ev[0].cs_rise,  tbl[i].cs_rise);
      chk($sformatf("row%0d dbdir", i),    int'(ev[0].dir), int'(tbl[i].dir));
    end

    // Zero setup: CS and write strobe together, DTACK three clocks later.
    run_txn(1'b1, 1'b0, 10, 0, 1'b0);
    chk("s0 cs_fall",  ev[1].cs_fall,  3);
    chk("s0 stb_fall", ev[1].stb_fall, 3);
    chk("s0 stb_rise", ev[1].stb_rise, 6);
    chk("s0 dt_fall",  ev[1].dt_fall,  6);

    run_random(30);

    // Reset asserted while both instances sit in ACK.
    @(posedge clk); #1;
    wizsel = 1'b1;
    dsl    = 1'b0;
    rdwl   = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("pre-reset dtack dut0", int'(a_dtackl), 0);
    chk("pre-reset dtack dut1", int'(b_dtackl), 0);
    #1;
    resetl = 1'b0;
    #1;
    chk_vec("async reset dut0", outv(0), RST_V);
    chk_vec("async reset dut1", outv(1), RST_V);
    tmo_flag = 1'b0;
    dsl      = 1'b1;
    wizsel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetl = 1'b1;
    repeat (3) @(posedge clk);
    run_txn(1'b1, 1'b1, 10, 0, 1'b0);
    chk("post-reset cs_fall", ev[0].cs_fall, 3);
    chk("post-reset dt_fall", ev[0].dt_fall, 7);

`ifdef QE_WIZ_TIMEOUT_EN
    // DS held low: watchdog ends ACK after TMO clocks and latches the flag.
    @(posedge clk); #1;
    wizsel = 1'b1;
    dsl    = 1'b0;
    rdwl   = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk); #1;
      if (n == 15) begin
        chk("tmo dut1 dtack@15", int'(b_dtackl), 0);
        chk("tmo dut1 flag@15",  int'(b_tmo),    0);
      end
      if (n == 16) begin
        chk("tmo dut0 dtack@16", int'(a_dtackl), 0);
        chk("tmo dut0 flag@16",  int'(a_tmo),    0);
        chk("tmo dut1 dtack@16", int'(b_dtackl), 1);
        chk("tmo dut1 flag@16",  int'(b_tmo),    1);
      end
      if (n == 17) begin
        chk("tmo dut0 dtack@17", int'(a_dtackl), 1);
        chk("tmo dut0 flag@17",  int'(a_tmo),    1);
      end
    end
    dsl    = 1'b1;
    wizsel = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tmo_flag = 1'b1;
    chk("tmo sticky dut0", int'(a_tmo), 1);
    chk("tmo sticky dut1", int'(b_tmo), 1);
    run_random(4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qe_wiz_cycle_ctrl.md
# qe_wiz_cycle_ctrl

Clocked bus-cycle sequencer between the QL expansion-bus address decoder and the W5300 Ethernet controller. Takes the decoder's W5300 select plus the raw 68008 strobes, synchronises them, and produces W5300 chip-select and read/write strobes with programmable setup, strobe and hold widths. It also drives the data-buffer enable and direction and generates DTACK only once the W5300 access has completed. The combinational decoder continues to own address matching and the 7-segment latch.

## Interface
- SETUP_CYC, 1: clocks of CS-before-strobe; 0 allowed (stage skipped)
- STROBE_CYC, 3: clocks of RD/WR low before DTACK; legal range 1..15
- HOLD_CYC, 1: clocks of CS/buffer released after DS negation; legal range 1..15
- TIMEOUT_CYC, 200: ACK watchdog limit; used only with QE_WIZ_TIMEOUT_EN
- clk  in  1  sequencer clock, free-running, at least 3x CPU clock
- resetl  in  1  asynchronous active-low reset
- wizsel  in  1  decoded W5300 address match, active high, asynchronous to clk
- dsl  in  1  68008 data strobe, active low, asynchronous
- rdwl  in  1  68008 read/write, 1 = read
- wizcsl  out  1  W5300 chip select, active low
- wizrdl  out  1  W5300 read strobe, active low
- wizwrl  out  1  W5300 write strobe, active low
- dbenl  out  1  data buffer enable, active low
- dbdir  out  1  data buffer direction, 1 = CPU to W5300
- dtackl  out  1  DTACK request, active low; top level converts it to open-drain
- timeout  out  1  sticky watchdog flag; always 0 without QE_WIZ_TIMEOUT_EN

## Operation
- Two-flop synchronisers on wizsel and dsl. Cycle start condition: synced wizsel = 1 and synced dsl = 0.
- rdwl is latched into rw_q on leaving IDLE and held for the whole cycle.
- States: IDLE -> SETUP -> STROBE -> ACK -> HOLD -> IDLE.
- IDLE: all outputs inactive. Enter SETUP on the start condition, or go directly to STROBE when SETUP_CYC = 0.
- SETUP: wizcsl = 0, dbenl = 0, strobes high. Lasts SETUP_CYC clocks, then STROBE.
- STROBE: wizcsl = 0, dbenl = 0, and wizrdl = 0 (read) or wizwrl = 0 (write). Lasts STROBE_CYC clocks, then ACK.
- ACK: dtackl = 0, wizcsl = 0, dbenl = 0.
  - Read: wizrdl is held low so data stays driven.
  - Write: wizwrl goes high on ACK entry, which is the W5300 latch edge.
  - Leave for HOLD when synced dsl = 1.
- HOLD: all strobes, wizcsl, dbenl and dtackl high for HOLD_CYC clocks, then IDLE. A new cycle is never accepted from HOLD.
- dbdir = ~rw_q from SETUP through HOLD; 0 in IDLE.
- Abort: synced dsl = 1 while in SETUP or STROBE sends the FSM to HOLD immediately, with no DTACK.
- A single 4-bit down-counter is shared by SETUP, STROBE and HOLD and is reloaded on every state entry.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset values: wizcsl = wizrdl = wizwrl = dbenl = dtackl = 1, dbdir = 0, timeout = 0, state IDLE, counter 0.
- resetl low mid-cycle returns every output to its reset value asynchronously, with no hold phase.
- Latency: the start condition becomes visible to the FSM 2 clocks after dsl falls. wizcsl falls on the following edge.
- DTACK falls SETUP_CYC + STROBE_CYC clocks after wizcsl falls.
- DTACK rises within 3 clocks of dsl rising: 2 synchroniser clocks plus 1 state transition.
- wizsel dropping while dsl stays low does not abort the cycle; only dsl ends it.

## Configuration
- QE_WIZ_TIMEOUT_EN defined:
  - An 8-bit counter runs in ACK.
  - On reaching TIMEOUT_CYC the FSM goes to HOLD and sets timeout = 1.
  - timeout clears only on reset.
- QE_WIZ_TIMEOUT_EN undefined: no counter; ACK waits indefinitely; timeout is tied to 0.

## Structure
- Package qe_bus_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, ACK, HOLD)
  - the counter width constant (4)
  - the timeout counter width (8)
- One sub-module, qe_sync2: a two-flop synchroniser with a reset value parameter. It is instantiated for wizsel (reset 0) and dsl (reset 1).

## Test plan
- Read with SETUP = 1, STROBE = 3, HOLD = 1:
  - dsl falls -> wizcsl low at clock 3, wizrdl low at clock 4, dtackl low at clock 7.
  - dsl rises -> dtackl, wizrdl, wizcsl high within 3 clocks, then IDLE 1 clock later.
- Write with the same parameters: wizwrl low for exactly 3 clocks and rising on the same edge dtackl falls; dbdir = 1 throughout.
- SETUP_CYC = 0: wizcsl and wizwrl fall on the same edge; dtackl follows 3 clocks later.
- Abort: dsl rises 1 clock into STROBE -> strobes high, dtackl never asserted, HOLD then IDLE.
- Reset mid-ACK: resetl pulsed low -> all outputs at reset values without waiting for a clock; next dsl falling edge starts a normal cycle.
- QE_WIZ_TIMEOUT_EN with TIMEOUT_CYC = 10 and dsl held low: dtackl high after 10 ACK clocks, timeout = 1 and stays 1 across later cycles.
